// File: rtl/sseg_scan_display_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment bit
// positions and the hex-digit segment code table (active-high, bit 0 = a).
// Optional feature macro used by the scanner: SSEG_LEADING_ZERO_BLANK_EN.
package sseg_scan_display_pkg;

  // Bit positions inside the 8-bit SSeg bus
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [SEG_G:SEG_A] seg_code_t;

  // Entry n is the lit-segment pattern (g..a) for hex digit n
  localparam seg_code_t [15:0] SEG_CODES = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic seg_code_t seg_lookup(input logic [3:0] nib);
    return SEG_CODES[nib];
  endfunction

endpackage

// File: rtl/sseg_digit_rom.sv
// Nibble to seven-segment code lookup (active-high, bit 0 = segment a).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
module sseg_digit_rom
  import sseg_scan_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_G:0]   code
);

  // Table lookup from the shared code constants
  always_comb begin
    code = seg_lookup(nibble);
  end

endmodule

// File: rtl/sseg_scan_display.sv
// Time-multiplexed seven-segment scanner: one digit per REFRESH_DIV-cycle slot.
// Latency: SSeg/An/Frame registered, 1 cycle after index/shadow/Blank.
// Backpressure: none. Optional macro SSEG_LEADING_ZERO_BLANK_EN darkens leading zeros.
module sseg_scan_display
  import sseg_scan_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] Hex,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic                    Load,
  input  logic                    Blank,
  output logic [7:0]              SSeg,
  output logic [NUM_DIGITS-1:0]   An,
  output logic                    Frame
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // XOR masks turning logical (1 = lit/on) values into pin levels; they are
  // also the reset values, so "off" is correct at the pins in both polarities.
  localparam logic [7:0]            SSEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [7:0]              sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic                    slot_end;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_lz;
  logic [SEG_G:0]          sel_code;
  logic                    dark;
  logic [7:0]              seg_lit;
  logic [NUM_DIGITS-1:0]   an_lit;

  sseg_digit_rom u_rom (
    .nibble (sel_nib),
    .code   (sel_code)
  );

  // Prescaler wraps every REFRESH_DIV cycles; the digit index steps on the wrap
  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow registers hold the displayed value between loads
  always_comb begin
    hex_d = Load ? Hex : hex_q;
    dp_d  = Load ? DP  : dp_q;
  end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_dark;
  logic                  lz_run;

  // Walk down from the top digit; darken zero/no-DP digits until one doesn't qualify
  always_comb begin
    lz_dark = '0;
    lz_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (hex_q[4*i +: 4] == 4'h0) && !dp_q[i]) begin
        lz_dark[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`endif

  // Pick the current digit's nibble, DP bit and leading-zero status
  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib = hex_q[4*i +: 4];
        sel_dp  = dp_q[i];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        sel_lz  = lz_dark[i];
`endif
      end
    end
  end

  // Next output values: lit pattern for the selected digit, then pin polarity
  always_comb begin
    dark    = Blank | sel_lz;
    seg_lit = '0;
    an_lit  = '0;
    if (!dark) begin
      seg_lit[SEG_G:SEG_A] = sel_code;
      seg_lit[SEG_DP]      = sel_dp;
      an_lit               = NUM_DIGITS'(1) << idx_q;
    end
    sseg_d  = seg_lit ^ SSEG_OFF;
    an_d    = an_lit ^ AN_OFF;
    frame_d = slot_end && (idx_q == IDX_LAST);
  end

  // All state, with synchronous reset to digit 0 / blank shadow / outputs off
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      sseg_q  <= SSEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      sseg_q  <= sseg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign SSeg  = sseg_q;
  assign An    = an_q;
  assign Frame = frame_q;

endmodule

// File: tb/tb_sseg_scan_display.sv
// Bench for sseg_scan_display: two instances (active-high and active-low) share
// stimulus; expectations come from a time-based model of the scan schedule.
module tb_sseg_scan_display;

  localparam int N = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  hex = '0;
  logic [3:0]   dp = '0;
  logic         load = 1'b0;
  logic         blank = 1'b0;

  logic [7:0]   sseg0, sseg1;
  logic [3:0]   an0, an1;
  logic         frame0, frame1;

  int total = 0;
  int bad = 0;

  // model state: e = edges since reset release, shadow copy, expected outputs
  int unsigned  e = 0;
  logic [15:0]  m_hex = '0;
  logic [3:0]   m_dp = '0;
  logic [7:0]   exp_sseg = '0;
  logic [3:0]   exp_an = '0;
  logic         exp_frame = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  sseg_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(0)) dut_hi (
    .CLK(clk), .RST(rst), .Hex(hex), .DP(dp), .Load(load), .Blank(blank),
    .SSeg(sseg0), .An(an0), .Frame(frame0));

  sseg_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1)) dut_lo (
    .CLK(clk), .RST(rst), .Hex(hex), .DP(dp), .Load(load), .Blank(blank),
    .SSeg(sseg1), .An(an1), .Frame(frame1));

  function automatic int cur_digit();
    return (e / R) % N;
  endfunction

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  function automatic logic lz_dark(int d);
    if (d == 0) return 1'b0;
    for (int j = d; j < N; j++) begin
      if (((m_hex >> (4*j)) & 16'hF) != 0 || m_dp[j]) return 1'b0;
    end
    return 1'b1;
  endfunction
`endif

  // Advance one clock edge and update the model from the inputs held across it
  task automatic tick();
    int d, pos;
    logic [3:0] nib;
    logic dk;
    @(posedge clk);
    if (rst) begin
      exp_sseg = '0; exp_an = '0; exp_frame = 1'b0;
      e = 0; m_hex = '0; m_dp = '0;
    end else begin
      d   = cur_digit();
      pos = e % R;
      nib = 4'((m_hex >> (4*d)) & 16'hF);
      exp_an    = 4'(1 << d);
      exp_sseg  = {m_dp[d], seg_tab[nib]};
      exp_frame = (pos == R-1) && (d == N-1);
      dk = blank;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      dk = dk | lz_dark(d);
`endif
      if (dk) begin exp_sseg = '0; exp_an = '0; end
      e++;
      if (load) begin m_hex = hex; m_dp = dp; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; hex = 16'($urandom); dp = 4'($urandom);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({an0, sseg0, frame0} !== 13'h0) begin
        bad++;
        $display("FAIL reset_hi k=%0d got an=%b sseg=%h frame=%b want 0/00/0", k, an0, sseg0, frame0);
      end
      total++;
      if ({an1, sseg1} !== 12'hFFF) begin
        bad++;
        $display("FAIL reset_lo k=%0d got an=%b sseg=%h want 1111/ff", k, an1, sseg1);
      end
    end
    rst = 1'b0; load = 1'b0;
    tick();
    total++;
    if (an0 !== 4'b0001 || sseg0 !== 8'h3F || frame0 !== 1'b0) begin
      bad++;
      $display("FAIL first_after_reset got an=%b sseg=%h frame=%b want 0001/3f/0", an0, sseg0, frame0);
    end
  endtask

  task automatic test_scan_1234();
    int last_f = -1;
    int nf = 0;
    hex = 16'h1234; dp = 4'b0000; load = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      load = 1'b0;
      total++;
      if ({an0, sseg0, frame0} !== {exp_an, exp_sseg, exp_frame}) begin
        bad++;
        $display("FAIL scan_1234 k=%0d got an=%b sseg=%h frame=%b want an=%b sseg=%h frame=%b",
                 k, an0, sseg0, frame0, exp_an, exp_sseg, exp_frame);
      end
      total++;
      if ({an1, sseg1} !== ~{exp_an, exp_sseg}) begin
        bad++;
        $display("FAIL scan_1234_lo k=%0d got an=%b sseg=%h want an=%b sseg=%h", k, an1, sseg1, ~exp_an, ~exp_sseg);
      end
      if (frame0 === 1'b1) begin
        if (last_f >= 0) begin
          total++;
          if (k - last_f != R*N) begin
            bad++;
            $display("FAIL frame_period got %0d want %0d", k - last_f, R*N);
          end
        end
        last_f = k;
        nf++;
      end
    end
    total++;
    if (nf < 3) begin
      bad++;
      $display("FAIL frame_count got %0d want >=3", nf);
    end
  endtask

  task automatic test_digit_sweep();
    for (int v = 0; v < 16; v++) begin
      hex = {12'($urandom), 4'(v)}; dp = 4'b0001; load = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < R*N; k++) begin
        tick();
        total++;
        if ({an0, sseg0, frame0} !== {exp_an, exp_sseg, exp_frame}) begin
          bad++;
          $display("FAIL sweep v=%0d got an=%b sseg=%h frame=%b want an=%b sseg=%h frame=%b",
                   v, an0, sseg0, frame0, exp_an, exp_sseg, exp_frame);
        end
        if (exp_an == 4'b0001) begin
          total++;
          if (sseg0 !== {1'b1, seg_tab[v]}) begin
            bad++;
            $display("FAIL sweep_code v=%0d got %h want %h", v, sseg0, {1'b1, seg_tab[v]});
          end
        end
      end
    end
  endtask

  task automatic test_blank();
    hex = 16'($urandom); dp = 4'($urandom); load = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k % 5 == 0) blank = ($urandom_range(0, 2) == 0);
      tick();
      load = 1'b0;
      total++;
      if ({an0, sseg0, frame0} !== {exp_an, exp_sseg, exp_frame}) begin
        bad++;
        $display("FAIL blank k=%0d blank=%b got an=%b sseg=%h frame=%b want an=%b sseg=%h frame=%b",
                 k, blank, an0, sseg0, frame0, exp_an, exp_sseg, exp_frame);
      end
      total++;
      if ({an1, sseg1} !== ~{exp_an, exp_sseg}) begin
        bad++;
        $display("FAIL blank_lo k=%0d got an=%b sseg=%h want an=%b sseg=%h", k, an1, sseg1, ~exp_an, ~exp_sseg);
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_rst_mid();
    int found = 0;
    hex = 16'h9876; dp = 4'b1010; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cur_digit() == 2) begin found = 1; break; end
      tick();
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL rst_mid_index got no index 2 within 40 cycles want index 2");
    end
    rst = 1'b1;
    tick();
    total++;
    if (an0 !== 4'b0000 || sseg0 !== 8'h00 || frame0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got an=%b sseg=%h frame=%b want 0000/00/0", an0, sseg0, frame0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (an0 !== 4'b0001 || sseg0 !== 8'h3F || {an1, sseg1} !== {4'b1110, 8'hC0}) begin
      bad++;
      $display("FAIL rst_release got an=%b sseg=%h lo_an=%b lo_sseg=%h want 0001/3f/1110/c0",
               an0, sseg0, an1, sseg1);
    end
  endtask

  task automatic test_load_at_advance();
    int d, found;
    logic [15:0] old_hex;
    logic [3:0]  old_dp;
    logic [7:0]  old_code, new_code;
    for (int rep = 0; rep < 3; rep++) begin
      found = 0;
      hex = 16'h1234; dp = 4'b0000; load = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (e % R == 0) begin found = 1; break; end
        tick();
      end
      total++;
      if (found == 0) begin
        bad++;
        $display("FAIL adv_align got no slot start within 20 cycles want slot start");
      end
      d = cur_digit();
      old_hex = m_hex; old_dp = m_dp;
      old_code = {old_dp[d], seg_tab[4'((old_hex >> (4*d)) & 16'hF)]};
      hex = ~old_hex; dp = ~old_dp; load = 1'b1;
      new_code = {dp[d], seg_tab[4'((hex >> (4*d)) & 16'hF)]};
      tick();
      load = 1'b0;
      total++;
      if (an0 !== 4'(1 << d) || sseg0 !== old_code || {an1, sseg1} !== ~{4'(1 << d), old_code}) begin
        bad++;
        $display("FAIL adv_old d=%0d got an=%b sseg=%h lo=%b/%h want an=%b sseg=%h",
                 d, an0, sseg0, an1, sseg1, 4'(1 << d), old_code);
      end
      tick();
      total++;
      if (an0 !== 4'(1 << d) || sseg0 !== new_code || {an1, sseg1} !== ~{4'(1 << d), new_code}) begin
        bad++;
        $display("FAIL adv_new d=%0d got an=%b sseg=%h lo=%b/%h want an=%b sseg=%h",
                 d, an0, sseg0, an1, sseg1, 4'(1 << d), new_code);
      end
    end
  endtask

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    hex = 16'h00A5; dp = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 2*R*N; k++) begin
      tick();
      total++;
      if (an0 === 4'b1000 || an0 === 4'b0100 || {an0, sseg0} !== {exp_an, exp_sseg}) begin
        bad++;
        $display("FAIL lzb_00a5 k=%0d got an=%b sseg=%h want an=%b sseg=%h", k, an0, sseg0, exp_an, exp_sseg);
      end
    end
    hex = 16'h0000; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 2*R*N; k++) begin
      tick();
      total++;
      if (!(an0 === 4'b0000 || (an0 === 4'b0001 && sseg0 === 8'h3F)) || {an0, sseg0} !== {exp_an, exp_sseg}) begin
        bad++;
        $display("FAIL lzb_0000 k=%0d got an=%b sseg=%h want an=%b sseg=%h", k, an0, sseg0, exp_an, exp_sseg);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 7) == 0);
      blank = ($urandom_range(0, 5) == 0);
      hex   = 16'($urandom);
      dp    = 4'($urandom);
      tick();
      total++;
      if ({an0, sseg0, frame0} !== {exp_an, exp_sseg, exp_frame}) begin
        bad++;
        $display("FAIL random k=%0d got an=%b sseg=%h frame=%b want an=%b sseg=%h frame=%b",
                 k, an0, sseg0, frame0, exp_an, exp_sseg, exp_frame);
      end
      total++;
      if ({an1, sseg1} !== ~{exp_an, exp_sseg}) begin
        bad++;
        $display("FAIL random_lo k=%0d got an=%b sseg=%h want an=%b sseg=%h", k, an1, sseg1, ~exp_an, ~exp_sseg);
      end
    end
    rst = 1'b0; load = 1'b0; blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_digit_sweep();
    test_blank();
    test_rst_mid();
    test_load_at_advance();
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
